// File: rtl/freq_meter.sv
// Frequency / period meter: counts synchronized sig_in rising edges over a
// fixed gate window, or measures clk cycles between consecutive edges.
module freq_meter #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             cont,
  input  logic             sig_in,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] result,
  output logic             ovf
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [GW-1:0]    GATE_ONE  = GW'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  // Timeout fires on the cycle the counter would step onto all-ones.
  localparam logic [CNT_W-1:0] CNT_TMO   = CNT_MAX - CNT_ONE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATE   = 2'd1,
    WAIT1  = 2'd2,
    PERIOD = 2'd3
  } state_t;

  state_t           state_r;
  logic             s1_r, s2_r, s3_r;
  logic             edge_s;
  logic [GW-1:0]    gate_cnt_r;
  logic [CNT_W-1:0] cnt_r;
  logic             sat_r;
  logic             busy_r, valid_r, ovf_r;
  logic [CNT_W-1:0] result_r;
  logic [CNT_W-1:0] freq_cnt_s;
  logic             freq_sat_s;

  assign edge_s = s2_r & ~s3_r;
  assign busy   = busy_r;
  assign valid  = valid_r;
  assign result = result_r;
  assign ovf    = ovf_r;

  // Two-flop synchronizer plus history flop for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= sig_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // Saturating edge count for the frequency gate, including this cycle's edge
  always_comb begin
    freq_cnt_s = cnt_r;
    freq_sat_s = sat_r;
    if (edge_s) begin
      if (cnt_r == CNT_MAX) begin
        freq_sat_s = 1'b1;
      end else begin
        freq_cnt_s = cnt_r + CNT_ONE;
      end
    end else begin
      freq_cnt_s = cnt_r;
    end
  end

  // Measurement FSM with registered status and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      gate_cnt_r <= '0;
      cnt_r      <= '0;
      sat_r      <= 1'b0;
      busy_r     <= 1'b0;
      valid_r    <= 1'b0;
      result_r   <= '0;
      ovf_r      <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            gate_cnt_r <= '0;
            cnt_r      <= '0;
            sat_r      <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= mode ? WAIT1 : GATE;
          end
        end
        GATE: begin
          if (gate_cnt_r == GATE_LAST) begin
            result_r   <= freq_cnt_s;
            ovf_r      <= freq_sat_s;
            valid_r    <= 1'b1;
            gate_cnt_r <= '0;
            cnt_r      <= '0;
            sat_r      <= 1'b0;
            busy_r     <= cont;
            state_r    <= cont ? GATE : IDLE;
          end else begin
            gate_cnt_r <= gate_cnt_r + GATE_ONE;
            cnt_r      <= freq_cnt_s;
            sat_r      <= freq_sat_s;
          end
        end
        WAIT1: begin
          if (edge_s) begin
            cnt_r   <= '0;
            state_r <= PERIOD;
          end else if (cnt_r == CNT_TMO) begin
            result_r <= CNT_MAX;
            ovf_r    <= 1'b1;
            valid_r  <= 1'b1;
            cnt_r    <= '0;
            busy_r   <= cont;
            state_r  <= cont ? WAIT1 : IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        PERIOD: begin
          // The terminating edge of one period is the opening edge of the next.
          if (edge_s) begin
            result_r <= cnt_r + CNT_ONE;
            ovf_r    <= 1'b0;
            valid_r  <= 1'b1;
            cnt_r    <= '0;
            busy_r   <= cont;
            state_r  <= cont ? PERIOD : IDLE;
          end else if (cnt_r == CNT_TMO) begin
            result_r <= CNT_MAX;
            ovf_r    <= 1'b1;
            valid_r  <= 1'b1;
            cnt_r    <= '0;
            busy_r   <= cont;
            state_r  <= cont ? WAIT1 : IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
